regfile_scheduler: RTL and testbench
====================================

# regfile_scheduler

Write-port arbiter and hazard scoreboard for the 8×16-bit register file. Sits between the issue stage and the two writeback sources, ALU and memory load. It:
- shares the single register-file write port between the two sources;
- tracks which registers have a write in flight;
- stalls issue on RAW/WAW hazards.

It drives the register file's regWrite/writeRegister/writeData/changeEnable inputs directly.

## Interface
- STARVE_LIMIT, default 4: consecutive cycles mem may be denied before it takes priority (1..15).
- clock  in  1  system clock; register file shares the same edge.
- reset  in  1  synchronous, active-high.
- issue_valid  in  1  instruction presented for issue.
- issue_rs  in  3  source register number.
- issue_rd  in  3  destination/second-source register number.
- issue_uses_rs  in  1  instruction reads rs.
- issue_uses_rd  in  1  instruction reads rd.
- issue_writes  in  1  instruction will write rd.
- issue_ready  out  1  no hazard; issue accepted when valid&ready.
- alu_wb_valid  in  1  ALU result available.
- alu_wb_reg  in  3  ALU destination register.
- alu_wb_data  in  16  ALU result.
- alu_wb_ready  out  1  ALU result granted this cycle.
- mem_wb_valid  in  1  load data available.
- mem_wb_reg  in  3  load destination register.
- mem_wb_data  in  16  load data.
- mem_wb_ready  out  1  load granted this cycle.
- regWrite  out  1  write strobe to register file.
- writeRegister  out  3  write address.
- writeData  out  16  write data.
- changeEnable  out  1  register-file update enable; equals regWrite.
- pending_mask  out  8  bit n set = write to r[n] in flight.
- err_unexpected  out  1  sticky: write granted to a non-pending register.

## Operation
- **Scoreboard.** pending[7:0] register.
  - Set pending[issue_rd] on accepted issue with issue_writes.
  - Clear pending[writeRegister] at the edge that ends a regWrite cycle.
- **issue_ready** (combinational from registered state) = !(uses_rs & pending[rs]) & !(uses_rd & pending[rd]) & !(writes & pending[rd]).
  - No bypass.
  - Because of this rule, set and clear of the same bit in one cycle cannot occur. If it does occur anyway, set wins.
- **Arbitration.** Combinational grant, one winner per cycle.
  - Default: ALU priority.
  - starve counter (4 bits): increments when mem_wb_valid & !mem_wb_ready; clears on mem grant or when mem_wb_valid is low.
  - When starve ≥ STARVE_LIMIT, mem wins over ALU.
  - The losing source holds valid/reg/data stable until granted; the sources must not drop valid.
- **Write stage.** Registered.
  - On a grant: regWrite/changeEnable=1 next cycle; writeRegister/writeData = the winner's reg/data.
  - No grant: regWrite=0; writeRegister/writeData hold their last value.
- **err_unexpected.** Set when a grant targets a register whose pending bit is 0. Cleared only by reset.
- **Reset.** All outputs and state cleared:
  - pending_mask=0, regWrite=0, changeEnable=0, writeRegister=0, writeData=0, err_unexpected=0, starve=0.
  - issue_ready=1 (follows from empty scoreboard), alu_wb_ready=0 and mem_wb_ready=0 while reset is high.
- **Reset mid-operation.** In-flight writes are discarded. The register file is cleared by the same reset.

## Timing
- Grant in cycle t → regWrite high in t+1 → register file and pending bit update at the end of t+1 → dependent issue_ready high in t+2, reading the new value.
- Issue accepted in cycle t → pending bit visible from t+1.
- Throughput: one register write per cycle. Back-to-back grants produce continuous regWrite.
- Worst-case mem wait under continuous ALU traffic: STARVE_LIMIT cycles, then mem granted on the next cycle.

## Test plan
- **Reset:** drive reset 2 cycles with both wb valid → pending_mask=0, regWrite=0, writeData=0, both readies 0, issue_ready=1.
- **RAW stall:**
  - Issue writes r3 (accepted) → pending_mask=8'h08.
  - Next instruction uses_rs r3 → issue_ready=0.
  - ALU wb r3=16'h1234 granted at t → regWrite=1, writeRegister=3, writeData=16'h1234 at t+1 → pending_mask=0, issue_ready=1 at t+2.
- **Collision:**
  - Pending r1, r2; ALU wb r1=16'hAAAA and mem wb r2=16'h5555 in the same cycle.
  - ALU granted first; mem granted the following cycle.
  - regWrite high two consecutive cycles with data AAAA then 5555; pending_mask 8'h06→8'h04→8'h00.
- **Starvation** (STARVE_LIMIT=4): ALU valid every cycle to pending registers, mem valid continuously.
  - mem_wb_ready low 4 cycles, high on the 5th; alu_wb_ready low that cycle.
- **WAW:** r5 pending; issue with writes & rd=5 → issue_ready=0 until r5's write completes. Unrelated rd=6 issue accepted immediately.
- **Error and reset mid-flight:**
  - ALU write to non-pending r7 → err_unexpected=1 and stays 1.
  - Reset asserted with r0/r4 pending and mem waiting → pending_mask=0, err_unexpected=0 after the reset edge.

Source files
------------

// File: rtl/regfile_scheduler.sv
// regfile_scheduler: decides which writeback source (ALU or memory load) uses
// the single register-file write port each cycle, remembers which registers
// still have a write outstanding, and holds off issue on RAW/WAW hazards.
module regfile_scheduler #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [2:0]  issue_rs,
  input  logic [2:0]  issue_rd,
  input  logic        issue_uses_rs,
  input  logic        issue_uses_rd,
  input  logic        issue_writes,
  output logic        issue_ready,
  input  logic        alu_wb_valid,
  input  logic [2:0]  alu_wb_reg,
  input  logic [15:0] alu_wb_data,
  output logic        alu_wb_ready,
  input  logic        mem_wb_valid,
  input  logic [2:0]  mem_wb_reg,
  input  logic [15:0] mem_wb_data,
  output logic        mem_wb_ready,
  output logic        regWrite,
  output logic [2:0]  writeRegister,
  output logic [15:0] writeData,
  output logic        changeEnable,
  output logic [7:0]  pending_mask,
  output logic        err_unexpected
);

  logic [7:0]  pending;
  logic [7:0]  pendingNext;
  logic [3:0]  starve;
  logic        memPriority;
  logic        aluGrant;
  logic        memGrant;
  logic        anyGrant;
  logic [2:0]  grantReg;
  logic [15:0] grantData;
  logic        issueAccept;

  // Hazard check against registered state only; a write becomes visible to
  // issue the cycle after the register file has taken it (no bypass).
  always_comb begin
    issue_ready = !(issue_uses_rs && pending[issue_rs])
               && !(issue_uses_rd && pending[issue_rd])
               && !(issue_writes  && pending[issue_rd]);
    issueAccept = issue_valid && issue_ready;
  end

  // Write-port arbitration: ALU first unless mem has been refused long enough.
  always_comb begin
    memPriority = (starve >= 4'(STARVE_LIMIT));
    memGrant    = !reset && mem_wb_valid && (memPriority || !alu_wb_valid);
    aluGrant    = !reset && alu_wb_valid && !memGrant;
    anyGrant    = aluGrant || memGrant;
    grantReg    = memGrant ? mem_wb_reg  : alu_wb_reg;
    grantData   = memGrant ? mem_wb_data : alu_wb_data;
    alu_wb_ready = aluGrant;
    mem_wb_ready = memGrant;
  end

  // Scoreboard update: retire the write in progress, then mark the newly
  // issued destination so that a set always beats a clear on the same bit.
  always_comb begin
    pendingNext = pending;
    if (regWrite) begin
      pendingNext[writeRegister] = 1'b0;
    end
    if (issueAccept && issue_writes) begin
      pendingNext[issue_rd] = 1'b1;
    end
  end

  // Registered state: scoreboard, starvation counter, write stage, error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending        <= '0;
      starve         <= '0;
      regWrite       <= 1'b0;
      writeRegister  <= '0;
      writeData      <= '0;
      err_unexpected <= 1'b0;
    end else begin
      pending  <= pendingNext;
      regWrite <= anyGrant;
      if (anyGrant) begin
        writeRegister <= grantReg;
        writeData     <= grantData;
        if (!pending[grantReg]) begin
          err_unexpected <= 1'b1;
        end
      end
      if (!mem_wb_valid || memGrant) begin
        starve <= '0;
      end else if (starve != 4'hF) begin
        starve <= starve + 4'd1;
      end
    end
  end

  assign changeEnable = regWrite;
  assign pending_mask = pending;

endmodule

// File: tb/tb_regfile_scheduler.sv
// Directed bench for regfile_scheduler: reset, RAW stall, collision,
// starvation, WAW and error/mid-flight reset, all against hand-computed values.
module tb_regfile_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [2:0]  issue_rs;
  logic [2:0]  issue_rd;
  logic        issue_uses_rs;
  logic        issue_uses_rd;
  logic        issue_writes;
  logic        issue_ready;
  logic        alu_wb_valid;
  logic [2:0]  alu_wb_reg;
  logic [15:0] alu_wb_data;
  logic        alu_wb_ready;
  logic        mem_wb_valid;
  logic [2:0]  mem_wb_reg;
  logic [15:0] mem_wb_data;
  logic        mem_wb_ready;
  logic        regWrite;
  logic [2:0]  writeRegister;
  logic [15:0] writeData;
  logic        changeEnable;
  logic [7:0]  pending_mask;
  logic        err_unexpected;

  int checkCount = 0;
  int failCount  = 0;

  regfile_scheduler #(.STARVE_LIMIT(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_rs       (issue_rs),
    .issue_rd       (issue_rd),
    .issue_uses_rs  (issue_uses_rs),
    .issue_uses_rd  (issue_uses_rd),
    .issue_writes   (issue_writes),
    .issue_ready    (issue_ready),
    .alu_wb_valid   (alu_wb_valid),
    .alu_wb_reg     (alu_wb_reg),
    .alu_wb_data    (alu_wb_data),
    .alu_wb_ready   (alu_wb_ready),
    .mem_wb_valid   (mem_wb_valid),
    .mem_wb_reg     (mem_wb_reg),
    .mem_wb_data    (mem_wb_data),
    .mem_wb_ready   (mem_wb_ready),
    .regWrite       (regWrite),
    .writeRegister  (writeRegister),
    .writeData      (writeData),
    .changeEnable   (changeEnable),
    .pending_mask   (pending_mask),
    .err_unexpected (err_unexpected)
  );

  // 10-unit clock period
  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock edge and settle just after it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // present one writing instruction for rd with no source reads, accept it
  task automatic issueWrite(input logic [2:0] rd);
    issue_valid   = 1'b1;
    issue_rs      = 3'd0;
    issue_rd      = rd;
    issue_uses_rs = 1'b0;
    issue_uses_rd = 1'b0;
    issue_writes  = 1'b1;
    step();
    issue_valid   = 1'b0;
    issue_writes  = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    issue_valid   = 1'b0;
    issue_rs      = '0;
    issue_rd      = '0;
    issue_uses_rs = 1'b0;
    issue_uses_rd = 1'b0;
    issue_writes  = 1'b0;
    alu_wb_valid  = 1'b1;
    alu_wb_reg    = 3'd2;
    alu_wb_data   = 16'h1111;
    mem_wb_valid  = 1'b1;
    mem_wb_reg    = 3'd3;
    mem_wb_data   = 16'h2222;

    // ---- reset with both writeback sources valid
    step();
    step();
    checkVal("rst_alu_ready", alu_wb_ready, 0);
    checkVal("rst_mem_ready", mem_wb_ready, 0);
    checkVal("rst_pending", pending_mask, 0);
    checkVal("rst_regWrite", regWrite, 0);
    checkVal("rst_changeEnable", changeEnable, 0);
    checkVal("rst_writeData", writeData, 0);
    checkVal("rst_writeRegister", writeRegister, 0);
    checkVal("rst_err", err_unexpected, 0);
    issue_uses_rs = 1'b1;
    issue_writes  = 1'b1;
    #1;
    checkVal("rst_issue_ready", issue_ready, 1);
    issue_uses_rs = 1'b0;
    issue_writes  = 1'b0;
    reset        = 1'b0;
    alu_wb_valid = 1'b0;
    mem_wb_valid = 1'b0;
    step();

    // ---- RAW stall on r3
    issueWrite(3'd3);
    checkVal("raw_pending_set", pending_mask, 8'h08);
    issue_valid   = 1'b1;
    issue_rs      = 3'd3;
    issue_uses_rs = 1'b1;
    alu_wb_valid  = 1'b1;
    alu_wb_reg    = 3'd3;
    alu_wb_data   = 16'h1234;
    #1;
    checkVal("raw_stall", issue_ready, 0);
    checkVal("raw_alu_grant", alu_wb_ready, 1);
    step();
    alu_wb_valid = 1'b0;
    #1;
    checkVal("raw_regWrite", regWrite, 1);
    checkVal("raw_changeEnable", changeEnable, 1);
    checkVal("raw_writeRegister", writeRegister, 3);
    checkVal("raw_writeData", writeData, 16'h1234);
    checkVal("raw_still_stalled", issue_ready, 0);
    checkVal("raw_pending_t1", pending_mask, 8'h08);
    step();
    checkVal("raw_pending_clr", pending_mask, 0);
    checkVal("raw_ready_t2", issue_ready, 1);
    checkVal("raw_regWrite_off", regWrite, 0);
    checkVal("raw_writeData_hold", writeData, 16'h1234);
    issue_valid   = 1'b0;
    issue_uses_rs = 1'b0;

    // ---- collision: ALU r1 and mem r2 in the same cycle
    issueWrite(3'd1);
    issueWrite(3'd2);
    checkVal("col_pending", pending_mask, 8'h06);
    alu_wb_valid = 1'b1;
    alu_wb_reg   = 3'd1;
    alu_wb_data  = 16'hAAAA;
    mem_wb_valid = 1'b1;
    mem_wb_reg   = 3'd2;
    mem_wb_data  = 16'h5555;
    #1;
    checkVal("col_alu_first", alu_wb_ready, 1);
    checkVal("col_mem_wait", mem_wb_ready, 0);
    step();
    alu_wb_valid = 1'b0;
    #1;
    checkVal("col_mem_second", mem_wb_ready, 1);
    checkVal("col_wr1", regWrite, 1);
    checkVal("col_data1", writeData, 16'hAAAA);
    checkVal("col_pending1", pending_mask, 8'h06);
    step();
    mem_wb_valid = 1'b0;
    checkVal("col_wr2", regWrite, 1);
    checkVal("col_data2", writeData, 16'h5555);
    checkVal("col_reg2", writeRegister, 2);
    checkVal("col_pending2", pending_mask, 8'h04);
    step();
    checkVal("col_pending3", pending_mask, 8'h00);
    checkVal("col_wr_off", regWrite, 0);

    // ---- starvation: ALU streams r0..r4, mem waits on r6
    for (int i = 0; i < 5; i++) issueWrite(3'(i));
    issueWrite(3'd6);
    checkVal("stv_pending", pending_mask, 8'h5F);
    alu_wb_valid = 1'b1;
    alu_wb_reg   = 3'd0;
    alu_wb_data  = 16'h1000;
    mem_wb_valid = 1'b1;
    mem_wb_reg   = 3'd6;
    mem_wb_data  = 16'hBEEF;
    for (int c = 0; c < 5; c++) begin
      #1;
      checkVal($sformatf("stv_mem_ready_c%0d", c), mem_wb_ready, (c == 4) ? 1 : 0);
      checkVal($sformatf("stv_alu_ready_c%0d", c), alu_wb_ready, (c == 4) ? 0 : 1);
      step();
      if (c < 4) begin
        alu_wb_reg  = 3'(c + 1);
        alu_wb_data = 16'h1000 + 16'(c + 1);
      end else begin
        mem_wb_valid = 1'b0;
        checkVal("stv_mem_reg", writeRegister, 6);
        checkVal("stv_mem_data", writeData, 16'hBEEF);
      end
    end
    #1;
    checkVal("stv_alu_resume", alu_wb_ready, 1);
    step();
    alu_wb_valid = 1'b0;
    checkVal("stv_alu_data", writeData, 16'h1004);
    step();
    step();
    checkVal("stv_pending_done", pending_mask, 0);
    checkVal("stv_no_err", err_unexpected, 0);

    // ---- WAW on r5, unrelated r6 goes straight through
    issueWrite(3'd5);
    checkVal("waw_pending", pending_mask, 8'h20);
    issue_valid  = 1'b1;
    issue_rd     = 3'd5;
    issue_writes = 1'b1;
    #1;
    checkVal("waw_stall", issue_ready, 0);
    issue_rd = 3'd6;
    #1;
    checkVal("waw_other_ready", issue_ready, 1);
    step();
    checkVal("waw_other_pending", pending_mask, 8'h60);
    issue_rd     = 3'd5;
    alu_wb_valid = 1'b1;
    alu_wb_reg   = 3'd5;
    alu_wb_data  = 16'h0005;
    #1;
    checkVal("waw_stall_grant", issue_ready, 0);
    step();
    alu_wb_valid = 1'b0;
    #1;
    checkVal("waw_stall_write", issue_ready, 0);
    step();
    checkVal("waw_release", issue_ready, 1);
    checkVal("waw_pending_after", pending_mask, 8'h40);
    issue_valid  = 1'b0;
    issue_writes = 1'b0;
    mem_wb_valid = 1'b1;
    mem_wb_reg   = 3'd6;
    mem_wb_data  = 16'h0006;
    step();
    mem_wb_valid = 1'b0;
    step();
    checkVal("waw_pending_clear", pending_mask, 0);

    // ---- unexpected write to r7, then reset with writes in flight
    checkVal("err_before", err_unexpected, 0);
    alu_wb_valid = 1'b1;
    alu_wb_reg   = 3'd7;
    alu_wb_data  = 16'h7777;
    step();
    alu_wb_valid = 1'b0;
    checkVal("err_set", err_unexpected, 1);
    step();
    step();
    checkVal("err_sticky", err_unexpected, 1);
    issueWrite(3'd0);
    issueWrite(3'd4);
    checkVal("mid_pending", pending_mask, 8'h11);
    alu_wb_valid = 1'b1;
    alu_wb_reg   = 3'd4;
    alu_wb_data  = 16'h4444;
    mem_wb_valid = 1'b1;
    mem_wb_reg   = 3'd0;
    mem_wb_data  = 16'h0F0F;
    #1;
    checkVal("mid_mem_waiting", mem_wb_ready, 0);
    reset = 1'b1;
    #1;
    checkVal("mid_alu_ready_rst", alu_wb_ready, 0);
    checkVal("mid_mem_ready_rst", mem_wb_ready, 0);
    step();
    checkVal("mid_pending_rst", pending_mask, 0);
    checkVal("mid_err_rst", err_unexpected, 0);
    checkVal("mid_regWrite_rst", regWrite, 0);
    checkVal("mid_writeData_rst", writeData, 0);
    reset        = 1'b0;
    alu_wb_valid = 1'b0;
    mem_wb_valid = 1'b0;
    step();
    checkVal("mid_pending_after", pending_mask, 0);
    checkVal("mid_regWrite_after", regWrite, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
